// File: rtl/bt_cmd_decoder_pkg.sv
// ----------------------------------------------------------------------------
// bt_cmd_pkg
//   Shared definitions for the Bluetooth command decoder:
//     - opcode byte values
//     - FSM state encoding
//     - saturating per-channel volume helpers (attenuation: 0 = loudest)
// ----------------------------------------------------------------------------
package bt_cmd_pkg;

    localparam logic [7:0] OP_PAUSE    = 8'h01;
    localparam logic [7:0] OP_NEXT     = 8'h02;
    localparam logic [7:0] OP_PRE      = 8'h03;
    localparam logic [7:0] OP_VOL_PLUS = 8'h04;
    localparam logic [7:0] OP_VOL_DEC  = 8'h05;
    localparam logic [7:0] OP_SET_VOL  = 8'h07;

    // Direct song selection occupies 0x40..0x7F; the low six bits are the index.
    localparam logic [7:0] OP_SEL_BASE = 8'h40;
    localparam logic [7:0] OP_SEL_MASK = 8'hC0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARG  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Louder: reduce attenuation, floor at 0.
    function automatic logic [7:0] vol_louder(input logic [7:0] ch,
                                              input logic [7:0] step);
        return (ch > step) ? (ch - step) : 8'd0;
    endfunction

    // Quieter: raise attenuation, ceiling at vmax. The sum is 9 bits so a
    // channel near 0xFF can never wrap back to a loud setting.
    function automatic logic [7:0] vol_quieter(input logic [7:0] ch,
                                               input logic [7:0] step,
                                               input logic [7:0] vmax);
        logic [8:0] sum;
        sum = {1'b0, ch} + {1'b0, step};
        return (sum >= {1'b0, vmax}) ? vmax : sum[7:0];
    endfunction

endpackage

// File: rtl/bt_cmd_decoder_if.sv
// ----------------------------------------------------------------------------
// bt_cmd_decoder_if
//   Received-byte stream from uart_rx into the command decoder.
//     i_rx_valid : 1-cycle strobe, i_rx_data holds a new byte
//     i_rx_data  : received byte
//   master = byte source (uart_rx / testbench), slave = decoder.
// ----------------------------------------------------------------------------
interface bt_cmd_decoder_if;
    logic       i_rx_valid;
    logic [7:0] i_rx_data;

    modport master (output i_rx_valid, output i_rx_data);
    modport slave  (input  i_rx_valid, input  i_rx_data);
endinterface

// File: rtl/bt_cycle_timer.sv
// ----------------------------------------------------------------------------
// bt_cycle_timer
//   32-bit loadable down-counter. Loading N makes `expired` high in the
//   (N+1)-th cycle after the load edge; the count then rests at 0.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     load        : load load_val at the next edge (has priority)
//     load_val    : value to load
//     expired     : count is zero
// ----------------------------------------------------------------------------
module bt_cycle_timer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_val,
    output logic        expired
);

    logic [31:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != 32'd0) begin
            count_reg <= count_reg - 32'd1;
        end
    end

    assign expired = (count_reg == 32'd0);

endmodule

// File: rtl/bt_cmd_decoder.sv
// ----------------------------------------------------------------------------
// bt_cmd_decoder
//   Decodes single-byte and opcode+argument commands from the UART byte
//   stream into song select, pause and per-channel volume attenuation, plus
//   display-hold flags and an error pulse.
//   Ports:
//     clk, rst_n     : clock, asynchronous active-low reset
//     rx             : received byte stream (slave modport)
//     o_vol          : {left, right} attenuation, 0 = loudest
//     o_song_select  : current song index
//     o_pause        : 1 = paused
//     o_next/o_pre/o_vol_plus/o_vol_dec : display flags, high HOLD_CYCLES
//     o_busy         : FSM is in HOLD or ARG
//     o_err          : 1-cycle pulse on bad opcode, bad index or arg timeout
// ----------------------------------------------------------------------------
module bt_cmd_decoder
    import bt_cmd_pkg::*;
#(
    parameter int          SONG_NUM    = 4,
    parameter int          SEL_W       = 3,
    parameter int          VOL_STEP    = 14,
    parameter logic [7:0]  VOL_MAX     = 8'hFC,
    parameter int unsigned HOLD_CYCLES = 5_000_000,
    parameter int unsigned ARG_TIMEOUT = 50_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bt_cmd_decoder_if.slave      rx,
    output logic [15:0]          o_vol,
    output logic [SEL_W-1:0]     o_song_select,
    output logic                 o_pause,
    output logic                 o_next,
    output logic                 o_pre,
    output logic                 o_vol_plus,
    output logic                 o_vol_dec,
    output logic                 o_busy,
    output logic                 o_err
);

    localparam logic [7:0]  STEP8     = 8'(VOL_STEP);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(SONG_NUM - 1);
    // The timer counts down to 0 inclusive, so load one less than the span.
    localparam logic [31:0] HOLD_LOAD = 32'(HOLD_CYCLES - 1);
    localparam logic [31:0] ARG_LOAD  = 32'(ARG_TIMEOUT - 1);

    state_t           state_reg,     state_next;
    logic [SEL_W-1:0] sel_reg,       sel_next;
    logic             pause_reg,     pause_next;
    logic [7:0]       vol_l_reg,     vol_l_next;
    logic [7:0]       vol_r_reg,     vol_r_next;
    logic             next_reg,      next_next;
    logic             pre_reg,       pre_next;
    logic             vplus_reg,     vplus_next;
    logic             vdec_reg,      vdec_next;
    logic             err_reg,       err_next;

    logic             tmr_load;
    logic [31:0]      tmr_val;
    logic             tmr_expired;

    logic [7:0]       arg_vol;

    // One timer serves both HOLD and ARG; the states are mutually exclusive.
    bt_cycle_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_expired)
    );

    assign arg_vol = (rx.i_rx_data > VOL_MAX) ? VOL_MAX : rx.i_rx_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            sel_reg   <= '0;
            pause_reg <= 1'b0;
            vol_l_reg <= 8'd0;
            vol_r_reg <= 8'd0;
            next_reg  <= 1'b0;
            pre_reg   <= 1'b0;
            vplus_reg <= 1'b0;
            vdec_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            pause_reg <= pause_next;
            vol_l_reg <= vol_l_next;
            vol_r_reg <= vol_r_next;
            next_reg  <= next_next;
            pre_reg   <= pre_next;
            vplus_reg <= vplus_next;
            vdec_reg  <= vdec_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        pause_next = pause_reg;
        vol_l_next = vol_l_reg;
        vol_r_next = vol_r_reg;
        next_next  = next_reg;
        pre_next   = pre_reg;
        vplus_next = vplus_reg;
        vdec_next  = vdec_reg;
        err_next   = 1'b0;
        tmr_load   = 1'b0;
        tmr_val    = HOLD_LOAD;

        case (state_reg)
            ST_IDLE: begin
                if (rx.i_rx_valid) begin
                    case (rx.i_rx_data)
                        OP_PAUSE: begin
                            pause_next = ~pause_reg;
                        end
                        OP_NEXT: begin
                            sel_next   = (sel_reg == SEL_LAST) ? '0 : sel_reg + 1'b1;
                            next_next  = 1'b1;
                            state_next = ST_HOLD;
                            tmr_load   = 1'b1;
                        end
                        OP_PRE: begin
                            sel_next   = (sel_reg == '0) ? SEL_LAST : sel_reg - 1'b1;
                            pre_next   = 1'b1;
                            state_next = ST_HOLD;
                            tmr_load   = 1'b1;
                        end
                        OP_VOL_PLUS: begin
                            vol_l_next = vol_louder(vol_l_reg, STEP8);
                            vol_r_next = vol_louder(vol_r_reg, STEP8);
                            vplus_next = 1'b1;
                            state_next = ST_HOLD;
                            tmr_load   = 1'b1;
                        end
                        OP_VOL_DEC: begin
                            vol_l_next = vol_quieter(vol_l_reg, STEP8, VOL_MAX);
                            vol_r_next = vol_quieter(vol_r_reg, STEP8, VOL_MAX);
                            vdec_next  = 1'b1;
                            state_next = ST_HOLD;
                            tmr_load   = 1'b1;
                        end
                        OP_SET_VOL: begin
                            state_next = ST_ARG;
                            tmr_load   = 1'b1;
                            tmr_val    = ARG_LOAD;
                        end
                        default: begin
                            if ((rx.i_rx_data & OP_SEL_MASK) == OP_SEL_BASE) begin
                                if (int'(rx.i_rx_data[5:0]) < SONG_NUM) begin
                                    sel_next = SEL_W'(rx.i_rx_data[5:0]);
                                end else begin
                                    err_next = 1'b1;
                                end
                            end else begin
                                err_next = 1'b1;
                            end
                        end
                    endcase
                end
            end

            // Incoming bytes are ignored here on purpose: the user is still
            // looking at the previous action's display flag.
            ST_HOLD: begin
                if (tmr_expired) begin
                    next_next  = 1'b0;
                    pre_next   = 1'b0;
                    vplus_next = 1'b0;
                    vdec_next  = 1'b0;
                    state_next = ST_IDLE;
                end
            end

            // A byte in the final window cycle still counts as the argument.
            ST_ARG: begin
                if (rx.i_rx_valid) begin
                    vol_l_next = arg_vol;
                    vol_r_next = arg_vol;
                    state_next = ST_IDLE;
                end else if (tmr_expired) begin
                    err_next   = 1'b1;
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign o_vol         = {vol_l_reg, vol_r_reg};
    assign o_song_select = sel_reg;
    assign o_pause       = pause_reg;
    assign o_next        = next_reg;
    assign o_pre         = pre_reg;
    assign o_vol_plus    = vplus_reg;
    assign o_vol_dec     = vdec_reg;
    assign o_busy        = (state_reg != ST_IDLE);
    assign o_err         = err_reg;

endmodule

// File: tb/tb_bt_cmd_decoder.sv
// ----------------------------------------------------------------------------
// tb_bt_cmd_decoder
//   Directed stimulus for bt_cmd_decoder (HOLD_CYCLES=8, ARG_TIMEOUT=20,
//   SONG_NUM=4). The driver pushes the expected full output snapshot and the
//   cycle it must appear in; the monitor pops on every DUT response event:
//   the cycle after a byte, a busy->idle transition, or the first cycle of
//   a reset assertion.
// ----------------------------------------------------------------------------
module tb_bt_cmd_decoder;

    localparam int HOLD = 8;
    localparam int ATO  = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] o_vol;
    logic [2:0]  o_song_select;
    logic        o_pause, o_next, o_pre, o_vol_plus, o_vol_dec, o_busy, o_err;

    bt_cmd_decoder_if rx_if ();

    bt_cmd_decoder #(
        .SONG_NUM    (4),
        .SEL_W       (3),
        .VOL_STEP    (14),
        .VOL_MAX     (8'hFC),
        .HOLD_CYCLES (HOLD),
        .ARG_TIMEOUT (ATO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rx            (rx_if.slave),
        .o_vol         (o_vol),
        .o_song_select (o_song_select),
        .o_pause       (o_pause),
        .o_next        (o_next),
        .o_pre         (o_pre),
        .o_vol_plus    (o_vol_plus),
        .o_vol_dec     (o_vol_dec),
        .o_busy        (o_busy),
        .o_err         (o_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int          stamp;   // required cycle, -1 = any
        logic [15:0] vol;
        logic [2:0]  sel;
        logic        pause;
        logic [3:0]  flags;   // {next, pre, vol_plus, vol_dec}
        logic        busy;
        logic        err;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    failures = 0;

    // Expected architectural state, updated by the stimulus before each push.
    logic [7:0] m_vol = 8'd0;
    logic [2:0] m_sel = 3'd0;
    logic       m_pause = 1'b0;

    task automatic push(input string nm, input int stamp, input logic [3:0] fl,
                        input logic bsy, input logic er);
        exp_t e;
        e.stamp = stamp;
        e.vol   = {m_vol, m_vol};
        e.sel   = m_sel;
        e.pause = m_pause;
        e.flags = fl;
        e.busy  = bsy;
        e.err   = er;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic send(input logic [7:0] b, input string nm, input logic [3:0] fl,
                        input logic bsy, input logic er, output int stamp);
        @(posedge clk);
        #1;
        rx_if.i_rx_valid = 1'b1;
        rx_if.i_rx_data  = b;
        stamp = cyc + 1;
        push(nm, stamp, fl, bsy, er);
        @(posedge clk);
        #1;
        rx_if.i_rx_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending responses, want 0", exp_q.size());
            exp_q.delete();
            name_q.delete();
        end
    endtask

    // Byte response is at `stamp`; the display flag drops and busy falls
    // HOLD cycles later.
    task automatic expect_release(input string nm, input int stamp);
        push(nm, stamp + HOLD, 4'b0000, 1'b0, 1'b0);
        drain();
    endtask

    task automatic do_reset(input string nm);
        @(posedge clk);
        #1;
        m_vol = 8'd0; m_sel = 3'd0; m_pause = 1'b0;
        push(nm, -1, 4'b0000, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drain();
    endtask

    // ---------------- monitor ----------------
    initial begin : monitor
        bit         rst_q, valid_q, busy_q, trig, ok;
        int         flag_cnt;
        exp_t       e;
        string      nm;
        logic [3:0] fl;
        rst_q = 1'b1; valid_q = 1'b0; busy_q = 1'b0; flag_cnt = 0;
        forever begin
            @(negedge clk);
            fl = {o_next, o_pre, o_vol_plus, o_vol_dec};
            trig = (!rst_n && rst_q) || (rst_n && (valid_q || (busy_q && !o_busy)));
            if (trig) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_response: got event at cyc=%0d, want none", cyc);
                end else begin
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    ok = (e.stamp < 0 || e.stamp == cyc) && o_vol === e.vol &&
                         o_song_select === e.sel && o_pause === e.pause &&
                         fl === e.flags && o_busy === e.busy && o_err === e.err;
                    if (!ok) begin
                        failures++;
                        $display("FAIL %s: got vol=%h sel=%0d pause=%b flags=%b busy=%b err=%b cyc=%0d, want vol=%h sel=%0d pause=%b flags=%b busy=%b err=%b cyc=%0d",
                                 nm, o_vol, o_song_select, o_pause, fl, o_busy, o_err, cyc,
                                 e.vol, e.sel, e.pause, e.flags, e.busy, e.err, e.stamp);
                    end else begin
                        $display("ok %s cyc=%0d vol=%h sel=%0d pause=%b flags=%b busy=%b err=%b",
                                 nm, cyc, o_vol, o_song_select, o_pause, fl, o_busy, o_err);
                    end
                end
            end
            // Display flag width and exclusivity
            if (!rst_n) begin
                flag_cnt = 0;
            end else if (fl != 4'b0000) begin
                flag_cnt++;
                if (!$onehot(fl)) begin
                    checks++;
                    failures++;
                    $display("FAIL flag_onehot: got flags=%b, want one hot", fl);
                end
            end else if (flag_cnt != 0) begin
                checks++;
                if (flag_cnt != HOLD) begin
                    failures++;
                    $display("FAIL flag_width: got %0d cycles, want %0d", flag_cnt, HOLD);
                end
                flag_cnt = 0;
            end
            rst_q   = rst_n;
            valid_q = rx_if.i_rx_valid;
            busy_q  = o_busy;
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int s, s2;
        rx_if.i_rx_valid = 1'b0;
        rx_if.i_rx_data  = 8'h00;
        push("reset_init", -1, 4'b0000, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drain();

        // 1. NEXT wraps 1,2,3,0; PRE from 0 wraps to 3
        for (int i = 1; i <= 4; i++) begin
            m_sel = 3'(i % 4);
            send(8'h02, "next", 4'b1000, 1'b1, 1'b0, s);
            expect_release("next_release", s);
        end
        m_sel = 3'd3;
        send(8'h03, "pre_wrap", 4'b0100, 1'b1, 1'b0, s);
        expect_release("pre_release", s);

        // 2. VOL_DEC saturates at 0xFC, VOL_PLUS saturates at 0
        for (int i = 0; i < 20; i++) begin
            m_vol = (int'(m_vol) + 14 >= 252) ? 8'hFC : m_vol + 8'd14;
            send(8'h05, "vol_dec", 4'b0001, 1'b1, 1'b0, s);
            expect_release("vol_dec_release", s);
        end
        for (int i = 0; i < 20; i++) begin
            m_vol = (m_vol > 8'd14) ? m_vol - 8'd14 : 8'd0;
            send(8'h04, "vol_plus", 4'b0010, 1'b1, 1'b0, s);
            expect_release("vol_plus_release", s);
        end

        // 3. SET_VOL: clamp, plain value, timeout
        send(8'h07, "set_vol_op", 4'b0000, 1'b1, 1'b0, s);
        m_vol = 8'hFC;
        send(8'hFF, "set_vol_ff", 4'b0000, 1'b0, 1'b0, s);
        drain();
        send(8'h07, "set_vol_op", 4'b0000, 1'b1, 1'b0, s);
        m_vol = 8'h30;
        send(8'h30, "set_vol_30", 4'b0000, 1'b0, 1'b0, s);
        drain();
        send(8'h07, "set_vol_alone", 4'b0000, 1'b1, 1'b0, s);
        push("arg_timeout", s + ATO, 4'b0000, 1'b0, 1'b1);
        drain();

        // 4. Direct select, bad index, bad opcode, pause toggle
        m_sel = 3'd1;
        send(8'h41, "sel_1", 4'b0000, 1'b0, 1'b0, s);
        send(8'h44, "sel_bad_idx", 4'b0000, 1'b0, 1'b1, s);
        send(8'h09, "bad_opcode", 4'b0000, 1'b0, 1'b1, s);
        m_pause = 1'b1;
        send(8'h01, "pause_on", 4'b0000, 1'b0, 1'b0, s);
        m_pause = 1'b0;
        send(8'h01, "pause_off", 4'b0000, 1'b0, 1'b0, s);
        drain();

        // 5. Byte during HOLD is dropped
        m_sel = 3'd2;
        send(8'h02, "next_hold", 4'b1000, 1'b1, 1'b0, s);
        send(8'h01, "pause_in_hold", 4'b1000, 1'b1, 1'b0, s2);
        expect_release("next_hold_release", s);

        // 6. Reset mid-HOLD and mid-ARG, then normal operation
        m_sel = 3'd3;
        send(8'h02, "next_pre_rst", 4'b1000, 1'b1, 1'b0, s);
        drain();
        do_reset("reset_mid_hold");
        send(8'h07, "set_vol_pre_rst", 4'b0000, 1'b1, 1'b0, s);
        drain();
        repeat (3) @(posedge clk);
        do_reset("reset_mid_arg");
        m_sel = 3'd1;
        send(8'h02, "next_after_rst", 4'b1000, 1'b1, 1'b0, s);
        expect_release("next_after_rst_release", s);

        repeat (4) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL leftover: got %0d pending responses, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
